img_win_fetch: RTL and testbench

IMG_WIN_FETCH -- requirements
Module: img_win_fetch

---
 rtl/epu_pkg.sv | 18 +
 rtl/img_addr_gen.sv | 16 +
 rtl/img_win_fetch.sv | 182 ++++++++++++++++++
 tb/tb_img_win_fetch.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/epu_pkg.sv
// Shared constants for the image-processing datapath: window size and
// the window-fetch FSM state encoding.
package epu_pkg;

    // Convolution window edge length and pixel count.
    localparam int KWIN    = 5;
    localparam int KWIN_SQ = KWIN * KWIN;

    // Window-fetch FSM states.
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_FILL25    = 3'd1;
    localparam state_t ST_WAIT_CONV = 3'd2;
    localparam state_t ST_FILL5     = 3'd3;
    localparam state_t ST_DONE      = 3'd4;

endpackage

// File: rtl/img_addr_gen.sv
// Row-major pixel address: base + y*IMG_W + x, wrapping at ADDR_W bits.
module img_addr_gen #(
    parameter int IMG_W  = 16,
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] x,
    input  logic [ADDR_W-1:0] y,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ADDR_W-1:0] ROW_PITCH = ADDR_W'(IMG_W);

    assign addr = base + (y * ROW_PITCH) + x;

endmodule

// File: rtl/img_win_fetch.sv
// Sliding 5x5 window fetcher: walks an image with stride 1, loading a full
// window at the start of each row and a single new column per step right.
module img_win_fetch
    import epu_pkg::*;
#(
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic              i_conv_done,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [7:0]        i_mem_rdata,
    output logic              o_image_new_25,
    output logic              o_image_new_5,
    output logic [7:0]        o_image,
    output logic              o_win_valid,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [ADDR_W-1:0] X_LAST   = ADDR_W'(IMG_W - KWIN);
    localparam logic [ADDR_W-1:0] Y_LAST   = ADDR_W'(IMG_H - KWIN);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [4:0]        N_FILL25 = 5'(KWIN_SQ);
    localparam logic [4:0]        N_FILL5  = 5'(KWIN);
    localparam logic [2:0]        LAST_IDX = 3'(KWIN - 1);

    state_t            state, state_nxt;
    logic [4:0]        cnt, cnt_nxt;
    logic [2:0]        row, row_nxt;
    logic [2:0]        col, col_nxt;
    logic [ADDR_W-1:0] x0, x0_nxt;
    logic [ADDR_W-1:0] y0, y0_nxt;
    logic [ADDR_W-1:0] base, base_nxt;
    logic              new_25, new_5, done_pulse;

    logic              in_fill;
    logic [4:0]        n_reads;
    logic              rd;
    logic              win_last;
    logic [ADDR_W-1:0] pix_x, pix_y, pix_addr;

    // cnt runs past the last read: one cycle for the final data strobe,
    // then one cycle carrying o_win_valid before WAIT_CONV.
    assign in_fill  = (state == ST_FILL25) || (state == ST_FILL5);
    assign n_reads  = (state == ST_FILL25) ? N_FILL25 : N_FILL5;
    assign rd       = in_fill && (cnt < n_reads);
    assign win_last = in_fill && (cnt == n_reads + 5'd1);

    assign pix_x = x0 + ADDR_W'(col);
    assign pix_y = y0 + ADDR_W'(row);

    img_addr_gen #(
        .IMG_W  (IMG_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .base (base),
        .x    (pix_x),
        .y    (pix_y),
        .addr (pix_addr)
    );

    assign o_mem_rd       = rd;
    assign o_mem_addr     = rd ? pix_addr : '0;
    assign o_image_new_25 = new_25;
    assign o_image_new_5  = new_5;
    assign o_image        = (new_25 || new_5) ? i_mem_rdata : 8'd0;
    assign o_win_valid    = win_last;
    assign o_busy         = (state != ST_IDLE);
    assign o_done         = done_pulse;

    // Next-state logic for the FSM, read counters and window origin.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        row_nxt   = row;
        col_nxt   = col;
        x0_nxt    = x0;
        y0_nxt    = y0;
        base_nxt  = base;

        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt = ST_FILL25;
                    base_nxt  = i_base_addr;
                    x0_nxt    = '0;
                    y0_nxt    = '0;
                    cnt_nxt   = '0;
                    row_nxt   = '0;
                    col_nxt   = '0;
                end
            end

            ST_FILL25, ST_FILL5: begin
                cnt_nxt = cnt + 5'd1;
                // Column-outer, row-inner; a column shift only reads column 4.
                if (rd) begin
                    if (row == LAST_IDX) begin
                        row_nxt = '0;
                        if (state == ST_FILL25) begin
                            col_nxt = col + 3'd1;
                        end
                    end else begin
                        row_nxt = row + 3'd1;
                    end
                end
                if (win_last) begin
                    state_nxt = ST_WAIT_CONV;
                    cnt_nxt   = '0;
                end
            end

            ST_WAIT_CONV: begin
                if (i_conv_done) begin
                    cnt_nxt = '0;
                    row_nxt = '0;
                    if (x0 < X_LAST) begin
                        x0_nxt    = x0 + ADDR_ONE;
                        col_nxt   = LAST_IDX;
                        state_nxt = ST_FILL5;
                    end else if (y0 < Y_LAST) begin
                        x0_nxt    = '0;
                        y0_nxt    = y0 + ADDR_ONE;
                        col_nxt   = '0;
                        state_nxt = ST_FILL25;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM, counter and window-origin registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            row   <= '0;
            col   <= '0;
            x0    <= '0;
            y0    <= '0;
            base  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            row   <= row_nxt;
            col   <= col_nxt;
            x0    <= x0_nxt;
            y0    <= y0_nxt;
            base  <= base_nxt;
        end
    end

    // Pixel strobes trail the read by one cycle to line up with memory data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            new_25     <= 1'b0;
            new_5      <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            new_25     <= rd && (state == ST_FILL25);
            new_5      <= rd && (state == ST_FILL5);
            done_pulse <= (state == ST_DONE);
        end
    end

endmodule

// File: tb/tb_img_win_fetch.sv
// Bench for img_win_fetch: a 6x6 and a 5x5 instance, randomized bases and
// conv-engine latencies, stray control pulses and a mid-pass reset.
module tb_img_win_fetch;

    localparam int AW = 16;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          start   = 1'b0;
    logic          conv    = 1'b0;
    logic [AW-1:0] base_in = '0;
    int            cur     = 0;

    logic          start6, conv6, rd6, n25_6, n5_6, wv6, busy6, done6;
    logic [AW-1:0] addr6;
    logic [7:0]    rdata6, img6;
    logic          start5, conv5, rd5, n25_5, n5_5, wv5, busy5, done5;
    logic [AW-1:0] addr5;
    logic [7:0]    rdata5, img5;

    assign start6 = start && (cur == 0);
    assign conv6  = conv && (cur == 0);
    assign start5 = start && (cur == 1);
    assign conv5  = conv && (cur == 1);

    img_win_fetch #(.IMG_W(6), .IMG_H(6), .ADDR_W(AW)) u_dut6 (
        .clk            (clk),
        .rst            (rst),
        .i_start        (start6),
        .i_base_addr    (base_in),
        .i_conv_done    (conv6),
        .o_mem_rd       (rd6),
        .o_mem_addr     (addr6),
        .i_mem_rdata    (rdata6),
        .o_image_new_25 (n25_6),
        .o_image_new_5  (n5_6),
        .o_image        (img6),
        .o_win_valid    (wv6),
        .o_busy         (busy6),
        .o_done         (done6)
    );

    img_win_fetch #(.IMG_W(5), .IMG_H(5), .ADDR_W(AW)) u_dut5 (
        .clk            (clk),
        .rst            (rst),
        .i_start        (start5),
        .i_base_addr    (base_in),
        .i_conv_done    (conv5),
        .o_mem_rd       (rd5),
        .o_mem_addr     (addr5),
        .i_mem_rdata    (rdata5),
        .o_image_new_25 (n25_5),
        .o_image_new_5  (n5_5),
        .o_image        (img5),
        .o_win_valid    (wv5),
        .o_busy         (busy5),
        .o_done         (done5)
    );

    always #5 clk = ~clk;

    // Pixel memory: each pixel's value is the low byte of its address.
    always @(posedge clk) begin
        rdata6 <= addr6[7:0];
        rdata5 <= addr5[7:0];
    end

    logic          m_rd, m_n25, m_n5, m_wv, m_busy, m_done;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_img;

    assign m_rd   = (cur == 0) ? rd6   : rd5;
    assign m_addr = (cur == 0) ? addr6 : addr5;
    assign m_n25  = (cur == 0) ? n25_6 : n25_5;
    assign m_n5   = (cur == 0) ? n5_6  : n5_5;
    assign m_img  = (cur == 0) ? img6  : img5;
    assign m_wv   = (cur == 0) ? wv6   : wv5;
    assign m_busy = (cur == 0) ? busy6 : busy5;
    assign m_done = (cur == 0) ? done6 : done5;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state: expected read addresses of the whole pass, and
    // the cycle window of the reads of the window currently being fetched.
    int            cyc = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] obs_q[$];
    int            win_start = -100;
    int            win_n = 0;
    int            done_due = -100;
    int            busy_from = 0;
    int            busy_to = 0;
    bit            pass_active = 1'b0;
    bit            prev_exp_rd = 1'b0;
    bit            prev_kind25 = 1'b0;
    logic [AW-1:0] prev_ea = '0;
    int            n_wv, n_done, n_n25, n_n5;
    int            first_rd_cyc, first_wv_cyc, done_cyc, start_cyc, final_conv_cyc;
    bit            mon_exp_rd;
    logic [AW-1:0] mon_ea;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic model_reset();
        exp_q.delete();
        win_n       = 0;
        win_start   = -100;
        done_due    = -100;
        pass_active = 1'b0;
        prev_exp_rd = 1'b0;
        prev_ea     = '0;
    endtask

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        mon_exp_rd = (win_n != 0) && (cyc >= win_start) && (cyc < win_start + win_n);
        mon_ea = '0;
        check("mem_rd", 32'(m_rd), 32'(mon_exp_rd));
        if (mon_exp_rd) begin
            if (exp_q.size() != 0) mon_ea = exp_q.pop_front();
            obs_q.push_back(m_addr);
            check("mem_addr", 32'(m_addr), 32'(mon_ea));
        end else begin
            check("mem_addr_idle", 32'(m_addr), 0);
        end
        check("new_25", 32'(m_n25), 32'(prev_exp_rd && prev_kind25));
        check("new_5", 32'(m_n5), 32'(prev_exp_rd && !prev_kind25));
        check("image", 32'(m_img), prev_exp_rd ? 32'(prev_ea[7:0]) : 0);
        check("win_valid", 32'(m_wv), 32'((win_n != 0) && (cyc == win_start + win_n + 1)));
        check("done", 32'(m_done), 32'(cyc == done_due));
        check("busy", 32'(m_busy), 32'(pass_active && (cyc > busy_from) && (cyc <= busy_to)));
        if (m_rd && first_rd_cyc < 0) first_rd_cyc = cyc;
        if (m_wv) begin
            n_wv++;
            if (first_wv_cyc < 0) first_wv_cyc = cyc;
        end
        if (m_done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (m_n25) n_n25++;
        if (m_n5) n_n5++;
        prev_exp_rd = mon_exp_rd;
        prev_kind25 = (win_n == 25);
        prev_ea     = mon_ea;
    end

    // One image pass on instance idx. delay>0 fixes the win_valid->conv_done
    // gap; spur injects ignored start/conv pulses; rst_mid resets on the
    // third read of the first column shift; now starts in the current cycle.
    task automatic run_pass(input int idx, input logic [AW-1:0] base, input int delay,
                            input bit spur, input bit rst_mid, input bit now);
        int w, nwin, guard, d;
        w    = (idx == 0) ? 6 : 5;
        nwin = (w - 4) * (w - 4);
        cur  = idx;
        exp_q.delete();
        obs_q.delete();
        for (int wy = 0; wy <= w - 5; wy++) begin
            for (int wx = 0; wx <= w - 5; wx++) begin
                if (wx == 0) begin
                    for (int c = 0; c < 5; c++)
                        for (int r = 0; r < 5; r++)
                            exp_q.push_back(base + AW'((wy + r) * w + c));
                end else begin
                    for (int r = 0; r < 5; r++)
                        exp_q.push_back(base + AW'((wy + r) * w + wx + 4));
                end
            end
        end
        n_wv = 0; n_done = 0; n_n25 = 0; n_n5 = 0;
        first_rd_cyc = -1; first_wv_cyc = -1; done_cyc = -1; final_conv_cyc = -1;

        if (!now) begin
            @(posedge clk); #1;
        end
        base_in     = base;
        start       = 1'b1;
        start_cyc   = cyc;
        busy_from   = cyc;
        busy_to     = 1 << 30;
        pass_active = 1'b1;
        done_due    = -100;
        win_start   = cyc + 1;
        win_n       = 25;
        @(posedge clk); #1;
        start = 1'b0;
        if (spur) begin
            @(posedge clk); #1;
            base_in = ~base;
            start   = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            conv  = 1'b1;
            @(posedge clk); #1;
            conv = 1'b0;
        end

        for (int wi = 0; wi < nwin; wi++) begin
            guard = 0;
            while (!m_wv && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) begin
                check("win_valid_timeout", guard, 0);
                model_reset();
                return;
            end
            d = (delay > 0) ? delay : int'($urandom_range(1, 5));
            repeat (d) @(posedge clk);
            #1;
            conv = 1'b1;
            if (wi == nwin - 1) begin
                final_conv_cyc = cyc;
                done_due       = cyc + 2;
                busy_to        = cyc + 1;
            end else begin
                win_start = cyc + 1;
                win_n     = (((wi + 1) % (w - 4)) == 0) ? 25 : 5;
            end
            @(posedge clk); #1;
            conv = 1'b0;
            if (rst_mid && win_n == 5 && wi != nwin - 1) begin
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b1;
                model_reset();
                #1;
                check("rst_rd", 32'(m_rd), 0);
                check("rst_busy", 32'(m_busy), 0);
                repeat (3) @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
            if (spur && wi != nwin - 1) begin
                conv = 1'b1;
                @(posedge clk); #1;
                conv    = 1'b0;
                base_in = ~base;
                start   = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end

        repeat (4) @(posedge clk);
        #1;
        check("windows", n_wv, nwin);
        check("done_count", n_done, 1);
        check("done_lag", done_cyc - final_conv_cyc, 2);
        check("reads_left", exp_q.size(), 0);
        check("new25_count", n_n25, 25 * (w - 4));
        check("new5_count", n_n5, 5 * (nwin - (w - 4)));
        check("first_rd_lat", first_rd_cyc - start_cyc, 1);
        check("first_wv_lat", first_wv_cyc - start_cyc, 27);
        pass_active = 1'b0;
        win_n       = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy6", 32'(busy6), 0);
        check("reset_busy5", 32'(busy5), 0);
        check("reset_rd6", 32'(rd6), 0);
        rst = 1'b0;

        // 6x6 image at 0x100, conv engine answering 3 cycles after each window.
        run_pass(0, 16'h0100, 3, 1'b0, 1'b0, 1'b1);
        check("first_addr", 32'(obs_q[0]), 32'h100);
        for (int i = 0; i < 5; i++) begin
            check("fill5_addr", 32'(obs_q[25 + i]), 32'h105 + 6 * i);
        end

        run_pass(1, AW'($urandom), -1, 1'b0, 1'b0, 1'b0);
        run_pass(0, AW'($urandom), -1, 1'b1, 1'b0, 1'b0);
        run_pass(1, AW'($urandom), -1, 1'b1, 1'b0, 1'b0);
        run_pass(0, 16'hFFF0, -1, 1'b0, 1'b0, 1'b0);

        // Reset mid column shift, then restart on the first edge after release.
        run_pass(0, AW'($urandom), 2, 1'b0, 1'b1, 1'b0);
        run_pass(0, 16'h0200, -1, 1'b0, 1'b0, 1'b1);
        check("restart_origin", 32'(obs_q[0]), 32'h200);

        for (int k = 0; k < 4; k++) begin
            run_pass(k % 2, AW'($urandom), -1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
